// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder: funct3 access codes,
// FSM state encoding and byte-enable width.
package dmem_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables/replicated data and load
// extraction with sign/zero extension. Offsets are forced to natural alignment.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [31:0]     wdata,
  input  logic [31:0]     word,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdata_sh,
  output logic [31:0]     load_val,
  output logic            load_ok,
  output logic            store_ok,
  output logic            misaligned
);

  logic [1:0]  off_eff;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    off_eff    = off;
    misaligned = 1'b0;
    be         = '0;
    wdata_sh   = '0;
    load_val   = '0;
    load_ok    = 1'b0;
    store_ok   = 1'b0;

    case (funct3)
      F3_H, F3_HU: begin
        off_eff    = {off[1], 1'b0};
        misaligned = off[0];
      end
      F3_W: begin
        off_eff    = 2'b00;
        misaligned = |off;
      end
      default: ;
    endcase

    sel_byte = word[{off_eff, 3'b000} +: 8];
    sel_half = word[{off_eff[1], 4'b0000} +: 16];

    // Only 000/001/010 are legal store codes; loads add the unsigned variants.
    case (funct3)
      F3_B: begin
        load_val = {{24{sel_byte[7]}}, sel_byte};
        load_ok  = 1'b1;
        be       = 4'b0001 << off_eff;
        wdata_sh = {4{wdata[7:0]}};
        store_ok = 1'b1;
      end
      F3_H: begin
        load_val = {{16{sel_half[15]}}, sel_half};
        load_ok  = 1'b1;
        be       = 4'b0011 << off_eff;
        wdata_sh = {2{wdata[15:0]}};
        store_ok = 1'b1;
      end
      F3_W: begin
        load_val = word;
        load_ok  = 1'b1;
        be       = 4'b1111;
        wdata_sh = wdata;
        store_ok = 1'b1;
      end
      F3_BU: begin
        load_val = {24'd0, sel_byte};
        load_ok  = 1'b1;
      end
      F3_HU: begin
        load_val = {16'd0, sel_half};
        load_ok  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: IDLE/BUSY/DONE handshake around a word-organised RAM.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (suppress misaligned accesses, pulse misalign).
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign
);

  // Handshake: a request (memread|memwrite) is held by the core while stall=1;
  // the result is presented for exactly one cycle in DONE with stall=0.
  dmem_state_t state, state_nxt;

  logic [IDX_W+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       f3_q;
  logic             wr_q;
  logic [31:0]      rdata_q;

  logic [31:0]      mem [DEPTH];

  logic             req;
  logic [IDX_W-1:0] word_idx;
  logic [BE_W-1:0]  be;
  logic [31:0]      wdata_sh;
  logic [31:0]      load_val;
  logic             load_ok;
  logic             store_ok;
  logic             lane_mis;
  logic             suppress;

  logic             unused_addr_bits;
  assign unused_addr_bits = ^addr[31:IDX_W+2];

  assign req      = memread | memwrite;
  assign word_idx = addr_q[IDX_W+1:2];

  dmem_lane_align u_lane (
    .funct3     (f3_q),
    .off        (addr_q[1:0]),
    .wdata      (wdata_q),
    .word       (mem[word_idx]),
    .be         (be),
    .wdata_sh   (wdata_sh),
    .load_val   (load_val),
    .load_ok    (load_ok),
    .store_ok   (store_ok),
    .misaligned (lane_mis)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;

  assign suppress = lane_mis;
  assign misalign = (state == DONE) && mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (state == BUSY) begin
      mis_q <= lane_mis;
    end
  end
`else
  logic unused_mis;

  assign unused_mis = lane_mis;
  assign suppress   = 1'b0;
  assign misalign   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stall = ((state == IDLE) && req) || (state == BUSY);
  assign rdata = (state == DONE) ? rdata_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        addr_q  <= addr[IDX_W+1:0];
        wdata_q <= wdata;
        f3_q    <= funct3;
        wr_q    <= memwrite;
      end
      if (state == BUSY) begin
        rdata_q <= (!wr_q && load_ok && !suppress) ? load_val : '0;
      end
    end
  end

  // RAM is not reset; an async reset during BUSY leaves state!=BUSY at the next edge.
  always_ff @(posedge clk) begin
    if (state == BUSY && wr_q && store_ok && !suppress) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

- Data-memory responder for the core's load/store path.
- Consumes the `memread`/`memwrite` strobes from the control decoder, together with the ALU address, store data and `funct3`.
- Performs byte/halfword/word accesses into an internal word-organised RAM.
- Holds the core with `stall` until the access completes.
- Sits between the execute stage and the write-back mux (`memtoreg` path).

## Interface
Parameters:
- `DEPTH`, 1024: RAM size in 32-bit words; must be a power of two.
- `IDX_W`, `$clog2(DEPTH)`: word-index width; derived, not overridden.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `memread`  in  1  load request; held stable by the core while `stall`=1.
- `memwrite`  in  1  store request; held stable by the core while `stall`=1.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; bits [7:0] or [15:0] are used for sb/sh.
- `funct3`  in  3  access size and sign.
- `rdata`  out  32  load result, extended to 32 bits; valid in DONE.
- `stall`  out  1  core must hold its PC and pipeline registers while high.
- `misalign`  out  1  one-cycle pulse in DONE when the access was misaligned (see Configuration).

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- A request is `req = memread | memwrite`.
- IDLE:
  - On `req`, latch `addr`, `wdata`, `funct3` and kind (write if `memwrite`, else read), then go to BUSY.
  - With no `req`, stay in IDLE.
- BUSY:
  - Write: update the selected byte lanes of word `addr[IDX_W+1:2]`.
  - Read: capture the word.
  - Then go to DONE.
- DONE:
  - Drive `rdata` from the captured word, then go to IDLE.
  - DONE ignores `req`; the core has advanced by the next edge.
- `stall = (state==IDLE && req) || state==BUSY`. It is combinational from `req` in IDLE and 0 in DONE.
- Both `memread` and `memwrite` high: treat as a write; `rdata`=0.
- Address wrap: the word index is `addr[IDX_W+1:2]` modulo DEPTH. Upper address bits are ignored, and there is no bus error.
- `funct3` handling:
  - 000 lb, 100 lbu: byte at `addr[1:0]`, sign- or zero-extended.
  - 001 lh, 101 lhu: halfword at `addr[1]`, sign- or zero-extended.
  - 010 lw: full word.
  - Stores use 000/001/010 for sb/sh/sw.
  - Other codes: no RAM change; `rdata`=0.
- `rdata` is 0 whenever the state is not DONE, and 0 for writes.
- RAM contents are not reset; simulation initial value is undefined.

## Timing
- Access latency is 3 cycles: request edge (IDLE→BUSY), BUSY→DONE, DONE→IDLE.
- `stall` is high for exactly 2 cycles per access: the IDLE cycle with `req` and the BUSY cycle.
- Back-to-back requests: a new `req` in the cycle after DONE (state is IDLE) starts the next access. There is no bubble beyond DONE.
- A store is committed at the BUSY→DONE edge. Read-after-write to the same word returns the new data.
- Reset values: state IDLE, `rdata`=0, `misalign`=0, `stall` follows the combinational rule (0 unless `req`).
- Reset mid-operation:
  - Asserting `rst` while in BUSY before the commit edge aborts the access; no RAM write occurs.
  - Asserting `rst` while in DONE clears `rdata` immediately.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned halfword (`addr[0]`=1) or word (`addr[1:0]`≠0) accesses are suppressed: no RAM write, `rdata`=0.
  - `misalign` pulses high during DONE.
- Not defined:
  - The low address bits are masked to natural alignment (halfword `addr[0]`=0, word `addr[1:0]`=0) and the access proceeds.
  - `misalign` is tied 0.

## Structure
- Package `dmem_pkg` holds:
  - `funct3` constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - The state enum `dmem_state_t` (IDLE, BUSY, DONE).
  - The byte-enable width constant (4).
- Sub-module `dmem_lane_align` (combinational) provides:
  - The 4-bit byte enable and shifted store data from `funct3` and `addr[1:0]`.
  - Load extraction and sign/zero extension.
- The FSM and RAM array stay in `data_mem_ctrl`.

## Test plan
- Reset then idle: `rst` pulse, no `req` -> `stall`=0, `rdata`=0, `misalign`=0 for 10 cycles.
- sw then lw: sw `addr`=0x10, `wdata`=0xDEADBEEF; then lw 0x10 -> `stall` high 2 cycles each, and `rdata`=0xDEADBEEF in DONE.
- Byte/half extension: after the sw above:
  - lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE.
  - lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
- Partial store: sb 0x11 with `wdata`=0x55, then lw 0x10 -> 0xDEAD55EF.
- Misaligned and wrap:
  - With the macro: lw 0x12 -> `misalign` pulse, `rdata`=0, RAM unchanged.
  - Without the macro: the same access returns the word at 0x10.
  - With DEPTH=1024, sw 0x1010 aliases word 4 (byte 0x10).
- Reset mid-access: sw 0x20 = 0x12345678, `rst` asserted during BUSY; after reset, lw 0x20 -> prior contents, not 0x12345678.
